dma_io_peripheral: RTL and testbench
====================================

DMA_IO_PERIPHERAL -- requirements
Module: dma_io_peripheral

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO depth in bytes; it SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width, matching the DMA data bus DB.
REQ-003 CLK  input  1  SHALL be the single clock; all logic SHALL be updated on its rising edge.
REQ-004 RESET_N  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 DIR  input  1  SHALL select the transfer direction: 0 = device-to-memory (the DMA reads the device through IOR_N); 1 = memory-to-device (the DMA writes the device through IOW_N).
REQ-006 DREQ  output  1  SHALL be the DMA request to this block's controller channel.
REQ-007 DACK  input  1  SHALL be the channel acknowledge from the controller, active high.
REQ-008 IOR_N / IOW_N  input  1 each  SHALL be the controller I/O read and write strobes, active low.
REQ-009 EOP_N  input  1  SHALL be the controller terminal-count / end-of-process indication, active low.
REQ-010 DB_IN  input  WIDTH  SHALL carry the bus data captured on a memory-to-device transfer.
REQ-011 DB_OUT / DB_OE  output  WIDTH / 1  SHALL carry the bus data and its output enable for a device-to-memory transfer.
REQ-012 PUSH_VALID, PUSH_DATA[WIDTH], PUSH_READY SHALL form the local producer port (valid/ready); the port SHALL be active only when DIR=0.
REQ-013 POP_VALID, POP_DATA[WIDTH], POP_READY SHALL form the local consumer port (valid/ready); the port SHALL be active only when DIR=1.
REQ-014 COUNT  output  log2(DEPTH)+1  SHALL report the FIFO occupancy.
REQ-015 TC  output  1  SHALL be a sticky terminal-count flag; TC_CLR  input  1  SHALL clear it.

Function
REQ-016 The FIFO SHALL be a single FIFO of DEPTH entries with wrapping read and write pointers; COUNT SHALL range 0..DEPTH and SHALL never overflow or underflow.
REQ-017 PUSH_READY SHALL equal (DIR=0 and COUNT<DEPTH), and a push SHALL occur on PUSH_VALID and PUSH_READY.
REQ-018 POP_VALID SHALL equal (DIR=1 and COUNT>0), POP_DATA SHALL be the FIFO head, and a pop SHALL occur on POP_VALID and POP_READY.
REQ-019 A local push or pop and a bus-side pop or push in the same cycle SHALL leave COUNT unchanged and SHALL lose no data.
REQ-020 The bus FSM SHALL have exactly the states IDLE, REQ, XFER and RELEASE.
REQ-021 IDLE: DREQ=0; the FSM SHALL go to REQ when TC=0 and either (DIR=0 and COUNT>0) or (DIR=1 and COUNT<DEPTH).
REQ-022 REQ: DREQ=1; the FSM SHALL go to XFER on the first cycle DACK=1.
REQ-023 XFER: DREQ=1 until the strobe is first sampled low, and 0 from the following cycle onward.
REQ-024 XFER with DIR=0: DB_OE=1 and DB_OUT=FIFO head combinationally while DACK=1 and IOR_N=0; one pop SHALL occur on the rising edge of IOR_N (previous sample 0, current sample 1).
REQ-025 XFER with DIR=1: DB_IN SHALL be registered on every cycle with IOW_N=0; the last registered value SHALL be pushed on the rising edge of IOW_N.
REQ-026 On the strobe rising edge the FSM SHALL go to RELEASE; RELEASE SHALL last exactly one cycle with DREQ=0 and then go to IDLE.
REQ-027 Exactly one byte SHALL be transferred per DREQ assertion (single-transfer mode).
REQ-028 If DACK falls in XFER before any strobe low is sampled, the FSM SHALL return to REQ with no FIFO change.
REQ-029 EOP_N sampled low in XFER SHALL set TC; the current byte SHALL still complete.
REQ-030 While TC=1, IDLE SHALL not leave IDLE.
REQ-031 TC_CLR=1 SHALL clear TC; if EOP_N sets TC in the same cycle, the set SHALL win.
REQ-032 A change of DIR outside IDLE SHALL be ignored until the FSM returns to IDLE; DIR SHALL be sampled only in IDLE.
REQ-033 A strobe for the inactive direction SHALL be ignored, and any strobe while DACK=0 SHALL be ignored.
REQ-034 When DB_OE=0, DB_OUT SHALL be 0.

Reset
REQ-035 RESET_N=0 SHALL immediately put the FSM in IDLE and set DREQ=0, DB_OE=0, DB_OUT=0, COUNT=0, both pointers to 0, TC=0, the strobe history to 1 and the DB_IN register to 0.
REQ-036 After reset, PUSH_READY and POP_VALID SHALL follow REQ-017 and REQ-018 combinationally.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer, discard the FIFO contents and drop DREQ asynchronously.
REQ-038 Reset deassertion SHALL take effect synchronously to CLK.

Verification
REQ-039 DIR=0, push 0xA5 -> DREQ=1 within 2 cycles; DACK=1, IOR_N low for 2 cycles -> DB_OUT=0xA5 with DB_OE=1 -> IOR_N rises -> COUNT=0, one RELEASE cycle, DREQ stays 0.
REQ-040 DIR=1, empty FIFO -> DREQ=1; DACK=1, DB_IN=0x3C, IOW_N low then high -> COUNT=1, POP_DATA=0x3C; repeat 8 times -> COUNT=8 and DREQ stays 0.
REQ-041 DIR=0, 8 pushes then a 9th attempt -> PUSH_READY=0 and COUNT=8; simultaneous push and IOR_N-rise pop -> COUNT stays 8; pointers wrap and data order is preserved.
REQ-042 EOP_N=0 during the XFER strobe -> byte completes, TC=1, DREQ stays 0 with data pending; TC_CLR -> DREQ reasserts.
REQ-043 DACK drops in XFER before a strobe -> FSM in REQ, DREQ=1, COUNT unchanged.
REQ-044 RESET_N=0 in XFER with DB_OE=1 -> DB_OE=0, DREQ=0, COUNT=0 in the same cycle, before the next CLK edge.

Source files
------------

// File: rtl/dma_io_peripheral_if.sv
// dma_io_peripheral_if: DMA bus, local push/pop ports and status of the DMA I/O peripheral.
interface dma_io_peripheral_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             dir;
    logic             dreq;
    logic             dack;
    logic             ior_n;
    logic             iow_n;
    logic             eop_n;
    logic [WIDTH-1:0] db_in;
    logic [WIDTH-1:0] db_out;
    logic             db_oe;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready;
    logic [CW-1:0]    count;
    logic             tc;
    logic             tc_clr;
    modport slave (
        input  dir, dack, ior_n, iow_n, eop_n, db_in, push_valid, push_data, pop_ready, tc_clr,
        output dreq, db_out, db_oe, push_ready, pop_valid, pop_data, count, tc
    );
    modport master (
        output dir, dack, ior_n, iow_n, eop_n, db_in, push_valid, push_data, pop_ready, tc_clr,
        input  dreq, db_out, db_oe, push_ready, pop_valid, pop_data, count, tc
    );
endinterface

// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral: byte FIFO bridging a local valid/ready port and a single-transfer DMA channel.
module dma_io_peripheral #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input logic clk_i,
    input logic rst_ni,
    dma_io_peripheral_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;
    state_t state_q, state_d;
    logic dir_q, strb_q, tc_q, tc_d;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q, count_d;
    logic dir, strb, rise, push, pop, wr, rd;
    // Direction is live only in IDLE; elsewhere the value latched there is used.
    assign dir  = (state_q == IDLE) ? bus.dir : dir_q;
    assign strb = dir ? bus.iow_n : bus.ior_n;
    assign rise = (state_q == XFER) && !strb_q && strb;
    assign push = bus.push_valid && bus.push_ready;
    assign pop  = bus.pop_valid && bus.pop_ready;
    assign wr   = push || (rise && dir);
    assign rd   = pop || (rise && !dir);
    assign bus.push_ready = !dir && (count_q != FULL);
    assign bus.pop_valid  = dir && (count_q != '0);
    assign bus.pop_data   = mem_q[rp_q];
    assign bus.db_oe      = (state_q == XFER) && !dir && bus.dack && !bus.ior_n;
    assign bus.db_out     = bus.db_oe ? mem_q[rp_q] : '0;
    // strb_q stays high until a low strobe is seen, so it also marks "request still pending".
    assign bus.dreq       = (state_q == REQ) || ((state_q == XFER) && strb_q);
    assign bus.count      = count_q;
    assign bus.tc         = tc_q;
    always_comb begin
        state_d = state_q;
        tc_d    = ((state_q == XFER) && !bus.eop_n) ? 1'b1 : bus.tc_clr ? 1'b0 : tc_q;
        count_d = (wr && !rd) ? count_q + CW'(1) : (rd && !wr) ? count_q - CW'(1) : count_q;
        case (state_q)
            IDLE:    if (!tc_q && (dir ? count_q != FULL : count_q != '0)) state_d = REQ;
            REQ:     if (bus.dack) state_d = XFER;
            XFER:    state_d = rise ? RELEASE : (strb_q && !bus.dack) ? REQ : XFER;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            strb_q  <= 1'b1;
            tc_q    <= 1'b0;
            din_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            count_q <= count_d;
            strb_q  <= ((state_q == XFER) && bus.dack) ? strb : 1'b1;
            if (state_q == IDLE) dir_q <= bus.dir;
            if ((state_q == XFER) && dir && bus.dack && !bus.iow_n) din_q <= bus.db_in;
            if (wr) wp_q <= wp_q + AW'(1);
            if (rd) rp_q <= rp_q + AW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wp_q] <= dir ? din_q : bus.push_data;
    end
endmodule

// File: tb/tb_dma_io_peripheral.sv
// tb_dma_io_peripheral: table-driven and scoreboard checks of the DMA I/O peripheral.
module tb_dma_io_peripheral;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_count;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int vecs = 0;
    int errs = 0;
    logic [7:0] sb [$];
    vec_t tab0 [3];
    vec_t tab1 [8];
    always #5 clk = ~clk;
    dma_io_peripheral_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    dma_io_peripheral #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
        check(name, 32'(bus.count), 32'(sb.size()));
    endtask

    task automatic push_byte(input logic [7:0] d);
        check("push_ready", 32'(bus.push_ready), 1);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        sb.push_back(d);
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic wait_dreq(input int n);
        for (int i = 0; i < n && !bus.dreq; i++) step();
        check("dreq_rise", 32'(bus.dreq), 1);
    endtask

    task automatic bus_read(input logic eop, input logic also_push, input logic [7:0] pd);
        logic [7:0] exp;
        wait_dreq(20);
        bus.dack = 1'b1;
        step();
        bus.ior_n  = 1'b0;
        bus.eop_n  = !eop;
        bus.tc_clr = eop;
        step();
        bus.eop_n  = 1'b1;
        bus.tc_clr = 1'b0;
        step();
        exp = sb.pop_front();
        check("db_oe", 32'(bus.db_oe), 1);
        check("db_out", 32'(bus.db_out), 32'(exp));
        check("dreq_xfer_rd", 32'(bus.dreq), 0);
        if (also_push) begin
            check("push_ready_rd", 32'(bus.push_ready), 1);
            bus.push_valid = 1'b1;
            bus.push_data  = pd;
            sb.push_back(pd);
        end
        bus.ior_n = 1'b1;
        step();
        bus.push_valid = 1'b0;
        check_count("count_rd");
        check("dreq_release_rd", 32'(bus.dreq), 0);
        bus.dack = 1'b0;
        step();
        check("dreq_idle_rd", 32'(bus.dreq), 0);
    endtask

    task automatic bus_write(input logic [7:0] d, input logic also_pop);
        wait_dreq(20);
        bus.dack = 1'b1;
        step();
        bus.db_in = d;
        bus.iow_n = 1'b0;
        step();
        check("dreq_xfer_wr", 32'(bus.dreq), 0);
        bus.db_in = ~d;
        bus.iow_n = 1'b1;
        if (also_pop) begin
            check("pop_data_wr", 32'(bus.pop_data), 32'(sb[0]));
            bus.pop_ready = 1'b1;
            void'(sb.pop_front());
        end
        sb.push_back(d);
        step();
        bus.pop_ready = 1'b0;
        check_count("count_wr");
        check("dreq_release_wr", 32'(bus.dreq), 0);
        bus.dack = 1'b0;
        step();
    endtask

    task automatic local_pop();
        check("pop_valid", 32'(bus.pop_valid), 1);
        check("pop_data", 32'(bus.pop_data), 32'(sb.pop_front()));
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0;
        check_count("count_pop");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab0 = '{'{8'h11, 4'd1}, '{8'h22, 4'd2}, '{8'h33, 4'd3}};
        tab1 = '{'{8'h3C, 4'd1}, '{8'h81, 4'd2}, '{8'h42, 4'd3}, '{8'hE7, 4'd4},
                 '{8'h18, 4'd5}, '{8'h5A, 4'd6}, '{8'hC9, 4'd7}, '{8'h06, 4'd8}};
        bus.dir = 1'b0; bus.dack = 1'b0; bus.ior_n = 1'b1; bus.iow_n = 1'b1; bus.eop_n = 1'b1;
        bus.db_in = '0; bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_ready = 1'b0; bus.tc_clr = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_count", 32'(bus.count), 0);
        check("rst_dreq", 32'(bus.dreq), 0);
        check("rst_db_oe", 32'(bus.db_oe), 0);
        check("rst_db_out", 32'(bus.db_out), 0);
        check("rst_tc", 32'(bus.tc), 0);
        check("rst_push_ready", 32'(bus.push_ready), 1);
        check("rst_pop_valid", 32'(bus.pop_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        // Single device-to-memory byte.
        push_byte(8'hA5);
        check_count("count_a5");
        wait_dreq(2);
        bus_read(1'b0, 1'b0, 8'h00);
        step();
        check("dreq_empty", 32'(bus.dreq), 0);
        foreach (tab0[i]) begin
            push_byte(tab0[i].data);
            check("tab0_count", 32'(bus.count), 32'(tab0[i].exp_count));
        end
        while (sb.size() > 0) bus_read(1'b0, 1'b0, 8'h00);
        // Fill, overflow attempt, concurrent push/pop, wrapped drain.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        check("full_count", 32'(bus.count), 8);
        check("full_push_ready", 32'(bus.push_ready), 0);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hEE;
        step();
        bus.push_valid = 1'b0;
        check("full_count_9th", 32'(bus.count), 8);
        bus_read(1'b0, 1'b0, 8'h00);
        bus_read(1'b0, 1'b1, 8'h77);
        check("count_concurrent_rd", 32'(bus.count), 7);
        while (sb.size() > 0) bus_read(1'b0, 1'b0, 8'h00);
        // DACK withdrawn before any strobe, then strobes without DACK.
        push_byte(8'h5A);
        wait_dreq(20);
        bus.dack = 1'b1;
        step();
        bus.dack = 1'b0;
        step();
        check("dack_drop_dreq", 32'(bus.dreq), 1);
        check("dack_drop_count", 32'(bus.count), 1);
        bus.ior_n = 1'b0;
        step();
        check("nodack_db_oe", 32'(bus.db_oe), 0);
        bus.ior_n = 1'b1;
        step();
        check("nodack_count", 32'(bus.count), 1);
        bus_read(1'b0, 1'b0, 8'h00);
        // Terminal count with simultaneous clear: set wins, then explicit clear.
        push_byte(8'hB1);
        push_byte(8'hB2);
        bus_read(1'b1, 1'b0, 8'h00);
        check("tc_set", 32'(bus.tc), 1);
        repeat (4) step();
        check("tc_dreq_held", 32'(bus.dreq), 0);
        check("tc_count", 32'(bus.count), 1);
        bus.tc_clr = 1'b1;
        step();
        bus.tc_clr = 1'b0;
        check("tc_cleared", 32'(bus.tc), 0);
        wait_dreq(3);
        bus_read(1'b0, 1'b0, 8'h00);
        // Asynchronous reset in the middle of a driven read strobe.
        push_byte(8'hC3);
        wait_dreq(20);
        bus.dack = 1'b1;
        step();
        bus.ior_n = 1'b0;
        #1;
        check("pre_rst_db_oe", 32'(bus.db_oe), 1);
        check("pre_rst_db_out", 32'(bus.db_out), 32'h C3);
        rst_n = 1'b0;
        #1;
        check("async_rst_db_oe", 32'(bus.db_oe), 0);
        check("async_rst_dreq", 32'(bus.dreq), 0);
        check("async_rst_count", 32'(bus.count), 0);
        check("async_rst_db_out", 32'(bus.db_out), 0);
        sb.delete();
        bus.ior_n = 1'b1;
        bus.dack  = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        // Memory-to-device direction.
        bus.dir = 1'b1;
        #1;
        check("dir1_pop_valid", 32'(bus.pop_valid), 0);
        check("dir1_push_ready", 32'(bus.push_ready), 0);
        foreach (tab1[i]) begin
            bus_write(tab1[i].data, 1'b0);
            check("tab1_count", 32'(bus.count), 32'(tab1[i].exp_count));
            check("tab1_head", 32'(bus.pop_data), 32'(sb[0]));
        end
        repeat (3) step();
        check("dir1_full_dreq", 32'(bus.dreq), 0);
        repeat (5) local_pop();
        bus_write(8'h99, 1'b1);
        check("count_concurrent_wr", 32'(bus.count), 3);
        while (sb.size() > 0) local_pop();
        check("dir1_empty_pop_valid", 32'(bus.pop_valid), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
